// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: stage-5 writeback vs. buffered multi-cycle results,
// with a starvation-forced drain and a pending-destination query for hazard logic.
module wb_port_arbiter #(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_valid,
  input  logic [REG_AW-1:0] pipe_rd,
  input  logic              pipe_memtoreg,
  input  logic [DATA_W-1:0] pipe_alu_val,
  input  logic [DATA_W-1:0] pipe_mem_val,
  input  logic              mc_valid,
  input  logic [REG_AW-1:0] mc_rd,
  input  logic [DATA_W-1:0] mc_data,
  output logic              mc_ready,
  output logic              stall_pipe,
  input  logic [REG_AW-1:0] q_rd,
  output logic              q_pending,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [REG_AW-1:0] XZR = REG_AW'(31);

  logic [REG_AW-1:0]     fifo_rd   [FIFO_DEPTH];
  logic [DATA_W-1:0]     fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_vld, fifo_vld_nxt;
  logic [PTR_W-1:0]      wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0]      count, count_nxt;
  logic [STV_W-1:0]      starve_cnt, starve_nxt;
  logic                  rf_we_nxt;
  logic [REG_AW-1:0]     rf_waddr_nxt;
  logic [DATA_W-1:0]     rf_wdata_nxt;
  logic                  full, empty, pipe_ok, enq, grant_pipe, grant_fifo;

  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign mc_ready   = !full;
  assign stall_pipe = (starve_cnt == STV_W'(STARVE_LIMIT));
  assign pipe_ok    = pipe_valid && (pipe_rd != XZR);
  // XZR beats complete the handshake but are dropped here.
  assign enq        = mc_valid && !full && (mc_rd != XZR);
  assign grant_fifo = !empty && (stall_pipe || !pipe_ok);
  assign grant_pipe = pipe_ok && !stall_pipe;

  // Next-state: FIFO bookkeeping, starvation counter and write-port selection.
  always_comb begin
    fifo_vld_nxt = fifo_vld;
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    count_nxt    = count;
    starve_nxt   = starve_cnt;
    rf_we_nxt    = grant_pipe || grant_fifo;
    rf_waddr_nxt = rf_waddr;
    rf_wdata_nxt = rf_wdata;

    if (grant_fifo) begin
      fifo_vld_nxt[rd_ptr] = 1'b0;
      rd_ptr_nxt           = rd_ptr + PTR_W'(1);
    end
    if (enq) begin
      fifo_vld_nxt[wr_ptr] = 1'b1;
      wr_ptr_nxt           = wr_ptr + PTR_W'(1);
    end

    case ({enq, grant_fifo})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase

    if (empty || grant_fifo) begin
      starve_nxt = '0;
    end else if (starve_cnt != STV_W'(STARVE_LIMIT)) begin
      starve_nxt = starve_cnt + STV_W'(1);
    end

    if (grant_fifo) begin
      rf_waddr_nxt = fifo_rd[rd_ptr];
      rf_wdata_nxt = fifo_data[rd_ptr];
    end else if (grant_pipe) begin
      rf_waddr_nxt = pipe_rd;
      rf_wdata_nxt = pipe_memtoreg ? pipe_mem_val : pipe_alu_val;
    end
  end

  // Hazard query: buffered entries plus a beat being accepted this cycle.
  always_comb begin
    q_pending = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (fifo_vld[i] && (fifo_rd[i] == q_rd)) q_pending = 1'b1;
    end
    if (enq && (mc_rd == q_rd)) q_pending = 1'b1;
    if (q_rd == XZR) q_pending = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_vld   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
    end else begin
      fifo_vld   <= fifo_vld_nxt;
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      count      <= count_nxt;
      starve_cnt <= starve_nxt;
      rf_we      <= rf_we_nxt;
      rf_waddr   <= rf_waddr_nxt;
      rf_wdata   <= rf_wdata_nxt;
    end
  end

  // Payload storage needs no reset; validity is tracked by fifo_vld.
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_rd[wr_ptr]   <= mc_rd;
      fifo_data[wr_ptr] <= mc_data;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed stimulus pushes expected writes,
// a negedge monitor pops and compares every register-file write.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic        pipe_memtoreg;
  logic [63:0] pipe_alu_val;
  logic [63:0] pipe_mem_val;
  logic        mc_valid;
  logic [4:0]  mc_rd;
  logic [63:0] mc_data;
  logic        mc_ready;
  logic        stall_pipe;
  logic [4:0]  q_rd;
  logic        q_pending;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_chk;
  int  n_fail;
  int  pidx;

  wb_port_arbiter #(
    .DATA_W(64), .REG_AW(5), .FIFO_DEPTH(2), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_memtoreg(pipe_memtoreg),
    .pipe_alu_val(pipe_alu_val), .pipe_mem_val(pipe_mem_val),
    .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_data(mc_data), .mc_ready(mc_ready),
    .stall_pipe(stall_pipe), .q_rd(q_rd), .q_pending(q_pending),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic [63:0] d);
    wr_t e;
    e.rd   = rd;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_valid    = 1'b0;
    pipe_rd       = '0;
    pipe_memtoreg = 1'b0;
    pipe_alu_val  = '0;
    pipe_mem_val  = '0;
    mc_valid      = 1'b0;
    mc_rd         = '0;
    mc_data       = '0;
  endtask

  // Scoreboard monitor: every observed write must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", rf_waddr, rf_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(rf_waddr), 64'(e.rd));
        check("wr_data", rf_wdata, e.data);
      end
    end
  end

  // Pipeline busy every cycle while mc beats arrive; masks give per-cycle expectations.
  task automatic contend(input int n_cyc, input int n_beats, input logic [31:0] stall_m,
                         input logic [31:0] ready_m, input logic [31:0] qp_m,
                         input logic [4:0] qrd);
    int m;
    int d;
    logic [63:0] pdata;
    m = 0;
    d = 0;
    for (int c = 0; c < n_cyc; c++) begin
      pipe_valid    = 1'b1;
      pipe_rd       = 5'(16 + pidx % 8);
      pipe_alu_val  = 64'hA000 + 64'(pidx);
      pipe_mem_val  = 64'hB000 + 64'(pidx);
      pipe_memtoreg = pidx[0];
      pdata         = pidx[0] ? 64'hB000 + 64'(pidx) : 64'hA000 + 64'(pidx);
      mc_valid      = (m < n_beats);
      mc_rd         = 5'(m + 1);
      mc_data       = 64'(m + 1) << 8;
      q_rd          = qrd;
      #1;
      check($sformatf("stall_c%0d", c), 64'(stall_pipe), 64'(stall_m[c]));
      if (m < n_beats) check($sformatf("mc_ready_c%0d", c), 64'(mc_ready), 64'(ready_m[c]));
      check($sformatf("q_pending_c%0d", c), 64'(q_pending), 64'(qp_m[c]));
      if (stall_m[c]) begin
        push(5'(d + 1), 64'(d + 1) << 8);
        d++;
      end else begin
        push(pipe_rd, pdata);
        pidx++;
      end
      if (m < n_beats && ready_m[c]) m++;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    logic [31:0] pend_vec;
    n_chk = 0;
    n_fail = 0;
    pidx = 0;
    q_rd = '0;
    idle_inputs();
    rst_n = 1'b0;

    // Reset values
    #3;
    check("rst_rf_we", 64'(rf_we), 64'(0));
    check("rst_waddr", 64'(rf_waddr), 64'(0));
    check("rst_wdata", rf_wdata, 64'(0));
    check("rst_stall", 64'(stall_pipe), 64'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    check("rel_mc_ready", 64'(mc_ready), 64'(1));
    tick();

    // Pipeline memtoreg select, then XZR destination
    pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_memtoreg = 1'b1;
    pipe_mem_val = 64'hDEAD; pipe_alu_val = 64'h1234;
    push(5'd5, 64'hDEAD);
    tick();
    check("pipe_mem_we", 64'(rf_we), 64'(1));
    check("pipe_mem_data", rf_wdata, 64'hDEAD);
    pipe_memtoreg = 1'b0;
    push(5'd5, 64'h1234);
    tick();
    check("pipe_alu_data", rf_wdata, 64'h1234);
    pipe_rd = 5'd31;
    tick();
    check("pipe_xzr_we", 64'(rf_we), 64'(0));
    check("hold_waddr", 64'(rf_waddr), 64'(5));
    check("hold_wdata", rf_wdata, 64'h1234);
    idle_inputs();
    tick();

    // Idle-pipe multi-cycle path
    q_rd = 5'd7;
    mc_valid = 1'b1; mc_rd = 5'd7; mc_data = 64'h42;
    #1;
    check("mc_ready_idle", 64'(mc_ready), 64'(1));
    check("qp_accept", 64'(q_pending), 64'(1));
    push(5'd7, 64'h42);
    tick();
    mc_valid = 1'b0;
    #1;
    check("qp_buffered", 64'(q_pending), 64'(1));
    check("mc_we_early", 64'(rf_we), 64'(0));
    tick();
    check("mc_we", 64'(rf_we), 64'(1));
    check("mc_waddr", 64'(rf_waddr), 64'(7));
    check("mc_wdata", rf_wdata, 64'h42);
    check("qp_popped", 64'(q_pending), 64'(0));
    tick();

    // XZR multi-cycle beats: handshake completes, nothing buffered or written
    q_rd = 5'd31;
    for (int i = 0; i < 3; i++) begin
      mc_valid = 1'b1; mc_rd = 5'd31; mc_data = 64'hBAD;
      #1;
      check($sformatf("xzr_ready_%0d", i), 64'(mc_ready), 64'(1));
      check($sformatf("xzr_qp_%0d", i), 64'(q_pending), 64'(0));
      tick();
    end
    idle_inputs();
    repeat (2) begin
      tick();
      check("xzr_no_write", 64'(rf_we), 64'(0));
    end

    // Starvation: one entry, forced drain on the fifth cycle after enqueue
    contend(8, 1, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0000_003F, 5'd1);
    repeat (2) tick();

    // Backpressure: three beats into a depth-2 FIFO under continuous pipeline writes
    contend(17, 3, 32'h0000_8420, 32'hFFFF_FFC3, 32'h0000_FFC0, 5'd3);
    repeat (2) tick();

    // Reset mid-stream with two buffered entries
    pipe_valid = 1'b1; pipe_rd = 5'd20; pipe_memtoreg = 1'b0;
    pipe_alu_val = 64'hC000; mc_valid = 1'b1; mc_rd = 5'd11; mc_data = 64'h1100;
    push(5'd20, 64'hC000);
    tick();
    pipe_alu_val = 64'hC001; mc_rd = 5'd12; mc_data = 64'h1200;
    push(5'd20, 64'hC001);
    tick();
    mc_valid = 1'b0; pipe_alu_val = 64'hC002;
    #1;
    check("full_ready", 64'(mc_ready), 64'(0));
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rf_we", 64'(rf_we), 64'(0));
    check("async_ready", 64'(mc_ready), 64'(1));
    idle_inputs();
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 64'(mc_ready), 64'(1));
    check("post_rst_stall", 64'(stall_pipe), 64'(0));
    pend_vec = '0;
    for (int r = 0; r < 32; r++) begin
      q_rd = 5'(r);
      #1;
      pend_vec[r] = q_pending;
    end
    check("post_rst_pending", 64'(pend_vec), 64'(0));
    repeat (8) tick();

    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
